stream_encryption: RTL and testbench
====================================

// Module: stream_encryption
// PURPOSE
//   Byte-stream encryptor; transmit-side counterpart of the decryption block.
//   Plaintext bytes on din/en are XORed with a keyed Galois-LFSR keystream and
//   the previous ciphertext byte, then rotated. The result is emitted on dout/v.
//   The decryption block, loaded with the same key, recovers the plaintext exactly.
// PARAMETERS
//   N     8         data width (bits); N <= KW
//   KW    16        key / LFSR width (bits)
//   TAPS  16'hB400  Galois LFSR feedback mask (KW bits)
//   ROT   3         left-rotate amount applied to each ciphertext byte, 0 <= ROT < N
//   WARM  16        LFSR warm-up steps after key load, WARM >= 1
// PORTS
//   clock   in   1   system clock, rising edge
//   rst     in   1   synchronous reset, active high
//   key_ld  in   1   load key; sampled every cycle
//   key     in   KW  key value, valid when key_ld = 1
//   en      in   1   plaintext byte valid
//   din     in   N   plaintext byte
//   ready   out  1   1 = block accepts en (state RUN)
//   dout    out  N   ciphertext byte
//   v       out  1   dout valid, one-cycle pulse per accepted byte
// BEHAVIOUR
//   Reset (rst=1 at a clock edge): state=IDLE; s=0; prev_c=0; wcnt=0;
//     dout=0; v=0; ready=0. Reset overrides all other inputs, including mid-stream.
//   FSM states: IDLE -> WARM -> RUN.
//     IDLE: no key loaded; en ignored; stays in IDLE until key_ld.
//     key_ld=1 in any state: s <= (key==0) ? 1 : key; prev_c <= 0; wcnt <= 0;
//       state <= WARM. key_ld has priority over en; a byte offered in that cycle
//       is dropped, and v=0 next cycle.
//     WARM: each cycle s <= step(s) and wcnt++. When wcnt == WARM-1, state <= RUN.
//       WARM therefore lasts exactly WARM cycles. en is ignored.
//     RUN: ready=1. en=1 accepts one byte.
//   step(s) = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1). The zero key is remapped to 1
//     so the LFSR cannot lock up.
//   Encrypt, on an accepted byte (RUN & en & !key_ld):
//     ks = s[N-1:0]
//     c = rotl(din ^ ks ^ prev_c, ROT), computed modulo N bits
//     Registered outputs: dout <= c; v <= 1; prev_c <= c; s <= step(s).
//   s advances only on accepted bytes in RUN, never on idle RUN cycles.
//   Latency: 1 cycle (byte sampled at edge k gives dout/v visible after edge k).
//     Throughput is 1 byte per cycle.
//   When no byte is accepted: v <= 0 and dout holds its last value.
//   ready is derived from the state register only (state==RUN); it has no
//     combinational path from inputs.
//   Decrypt relation: p = rotr(c, ROT) ^ ks ^ prev_c, using the same key,
//     WARM, TAPS, and byte order.
// TESTING
//   1 Reset: rst=1 for 3 cycles with en=1, din=8'hFF -> dout=0, v=0, ready=0
//     throughout. Release rst with no key_ld -> ready stays 0 and v stays 0.
//   2 Warm-up timing: key_ld with key=16'h1234 at edge t -> ready=0 for edges
//     t+1..t+16, ready=1 after edge t+16. en during WARM produces no v.
//   3 Known vector (WARM=1, key=16'h0001): s=16'hB400 after warm-up. Send
//     din=8'h0B twice back-to-back -> dout=8'h58, then 8'h9A, with v=1 on two
//     consecutive cycles. s=16'h2D00 afterwards.
//   4 Zero key: key=0 behaves identically to key=16'h0001 (repeat test 3,
//     same outputs).
//   5 Collision and rekey: in RUN, assert key_ld and en in the same cycle ->
//     v=0 next cycle; ready drops for WARM cycles; prev_c is reset (first
//     byte after rekey matches test 3).
//   6 Round trip: 256 random bytes with random en gaps go through this block
//     into the decryption block (same key). Decrypted output equals the input
//     sequence; v count equals the en-accepted count. Apply rst mid-stream,
//     then reload the key -> stream resynchronises.

Source files
------------

// File: rtl/stream_encryption.sv
// stream_encryption
//   Byte-stream encryptor. Each accepted plaintext byte is XORed with the low
//   byte of a keyed Galois LFSR and with the previous ciphertext byte. The
//   result is rotated left and registered onto dout with a one-cycle v pulse.
//   A matching decryptor loaded with the same key recovers the plaintext.
//
// Ports
//   clock   in   1    system clock, rising edge
//   rst     in   1    synchronous reset, active high
//   key_ld  in   1    load key; takes priority over en
//   key     in   KW   key value, valid with key_ld
//   en      in   1    plaintext byte valid
//   din     in   N    plaintext byte
//   ready   out  1    block accepts en (state RUN)
//   dout    out  N    ciphertext byte, held between pulses
//   v       out  1    dout valid, one pulse per accepted byte
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no key loaded, en ignored
// WARM    | LFSR stepping once per cycle for WARM cycles, en ignored
// RUN     | ready=1, one byte accepted per cycle with en
module stream_encryption #(
  parameter int             N    = 8,
  parameter int             KW   = 16,
  parameter logic [KW-1:0]  TAPS = 16'hB400,
  parameter int             ROT  = 3,
  parameter int             WARM = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          key_ld,
  input  logic [KW-1:0] key,
  input  logic          en,
  input  logic [N-1:0]  din,
  output logic          ready,
  output logic [N-1:0]  dout,
  output logic          v
);

  localparam int CW = (WARM > 1) ? $clog2(WARM) : 1;
  localparam logic [CW-1:0] WLOAD = CW'(WARM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WARM, ST_RUN} state_t;

  state_t        state, state_n;
  logic [KW-1:0] s, s_n;
  logic [N-1:0]  prev_c, prev_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [N-1:0]  dout_n;
  logic          v_n;
  logic          accept;
  logic [N-1:0]  mix, c;

  function automatic logic [KW-1:0] step(input logic [KW-1:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x);
    return (x << ROT) | (x >> (N - ROT));
  endfunction

  assign accept = (state == ST_RUN) && en && !key_ld;
  assign mix    = din ^ s[N-1:0] ^ prev_c;
  assign c      = rotl(mix);
  assign ready  = (state == ST_RUN);

  always_comb begin
    state_n = state;
    s_n     = s;
    prev_n  = prev_c;
    wcnt_n  = wcnt;
    dout_n  = dout;
    v_n     = 1'b0;
    if (key_ld) begin
      // a zero key would lock the LFSR at zero forever
      s_n     = (key == '0) ? KW'(1) : key;
      prev_n  = '0;
      wcnt_n  = WLOAD;
      state_n = ST_WARM;
    end else begin
      case (state)
        ST_WARM: begin
          s_n = step(s);
          if (wcnt == '0) state_n = ST_RUN;
          else            wcnt_n  = wcnt - 1'b1;
        end
        ST_RUN: begin
          if (accept) begin
            dout_n = c;
            v_n    = 1'b1;
            prev_n = c;
            s_n    = step(s);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= ST_IDLE;
      s      <= '0;
      prev_c <= '0;
      wcnt   <= '0;
      dout   <= '0;
      v      <= 1'b0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      prev_c <= prev_n;
      wcnt   <= wcnt_n;
      dout   <= dout_n;
      v      <= v_n;
    end
  end

endmodule

// File: tb/tb_stream_encryption.sv
module tb_stream_encryption;

  logic        clock = 1'b0;
  logic        rst;
  logic        a_key_ld, a_en, a_ready, a_v;
  logic [15:0] a_key;
  logic [7:0]  a_din, a_dout;
  logic        b_key_ld, b_en, b_ready, b_v;
  logic [15:0] b_key;
  logic [7:0]  b_din, b_dout;

  int nchk  = 0;
  int nfail = 0;

  logic [7:0] qa[$];   // expected plaintext for instance a (after decryption)
  logic [7:0] qb[$];   // expected ciphertext for instance b
  int a_vcount = 0;
  int a_acc    = 0;

  logic        lat_a_ld;
  logic [15:0] lat_a_key;
  logic [15:0] ds;
  logic [7:0]  dprev;

  always #5 clock = ~clock;

  stream_encryption dut_a (
    .clock(clock), .rst(rst), .key_ld(a_key_ld), .key(a_key), .en(a_en),
    .din(a_din), .ready(a_ready), .dout(a_dout), .v(a_v)
  );

  stream_encryption #(.WARM(1)) dut_b (
    .clock(clock), .rst(rst), .key_ld(b_key_ld), .key(b_key), .en(b_en),
    .din(b_din), .ready(b_ready), .dout(b_dout), .v(b_v)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [15:0] warmup(input logic [15:0] k);
    logic [15:0] x;
    x = (k == 16'h0) ? 16'h0001 : k;
    for (int i = 0; i < 16; i++) x = lstep(x);
    return x;
  endfunction

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  // key loads seen by instance a, for the reference decryptor
  always @(posedge clock) begin
    lat_a_ld  <= !rst && a_key_ld;
    lat_a_key <= a_key;
  end

  // monitor a: decrypt each ciphertext pulse and compare with the plaintext sent
  always @(negedge clock) begin
    logic [7:0] p, r;
    if (lat_a_ld === 1'b1) begin
      ds    = warmup(lat_a_key);
      dprev = 8'h00;
    end
    if (a_v === 1'b1) begin
      a_vcount++;
      r     = {a_dout[2:0], a_dout[7:3]};
      p     = r ^ ds[7:0] ^ dprev;
      dprev = a_dout;
      ds    = lstep(ds);
      if (qa.size() == 0) check("a_unexpected_v", 32'(a_dout), 32'hFFFF_FFFF);
      else                check("a_roundtrip", 32'(p), 32'(qa.pop_front()));
    end
  end

  // monitor b: compare ciphertext against hand-computed vectors
  always @(negedge clock) begin
    if (b_v === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_v", 32'(b_dout), 32'hFFFF_FFFF);
      else                check("b_cipher", 32'(b_dout), 32'(qb.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic wait_ready_a(input string name);
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < 40) begin cyc; n++; end
    check(name, 32'(a_ready), 32'd1);
  endtask

  initial begin
    bit did_rst;
    rst = 1'b1;
    a_key_ld = 0; a_key = 0; a_en = 1; a_din = 8'hFF;
    b_key_ld = 0; b_key = 0; b_en = 1; b_din = 8'hFF;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      cyc;
      check("rst_dout", 32'(a_dout), 32'h0);
      check("rst_v", 32'(a_v), 32'h0);
      check("rst_ready", 32'(a_ready), 32'h0);
      check("rst_ready_b", 32'(b_ready), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc;
      check("idle_ready", 32'(a_ready), 32'h0);
      check("idle_v", 32'(a_v), 32'h0);
      check("idle_v_b", 32'(b_v), 32'h0);
    end
    b_en = 0;

    // 2: warm-up timing, en held high through WARM
    a_key = 16'h1234; a_key_ld = 1; a_din = 8'h55;
    cyc;
    a_key_ld = 0;
    check("warm_ready_t", 32'(a_ready), 32'h0);
    for (int i = 1; i <= 15; i++) begin
      cyc;
      check("warm_ready", 32'(a_ready), 32'h0);
      check("warm_v", 32'(a_v), 32'h0);
    end
    cyc;
    a_en = 0;
    check("warm_done_ready", 32'(a_ready), 32'h1);
    check("warm_done_v", 32'(a_v), 32'h0);

    // 6: round trip with random gaps, reset and rekey mid-stream
    did_rst = 0;
    while (a_acc < 256) begin
      if (a_acc == 128 && !did_rst) begin
        did_rst = 1;
        a_en = 1; a_din = 8'hA5; rst = 1;
        cyc; cyc;
        check("mid_rst_ready", 32'(a_ready), 32'h0);
        rst = 0; a_en = 0;
        a_key = 16'h0000; a_key_ld = 1;
        cyc;
        a_key_ld = 0;
        a_key = 16'h5A5A; a_key_ld = 1;   // second load restarts warm-up
        cyc;
        a_key_ld = 0;
        wait_ready_a("rekey_ready");
      end else begin
        a_en  = ($urandom_range(0, 3) != 0);
        a_din = 8'($urandom);
        if (a_en && a_ready) begin
          qa.push_back(a_din);
          a_acc++;
        end
        cyc;
      end
    end
    a_en = 0;
    cyc; cyc; cyc;
    check("rt_queue_empty", 32'(qa.size()), 32'd0);
    check("rt_vcount", 32'(a_vcount), 32'(a_acc));

    // 3: known vector, WARM=1, key=1
    b_key = 16'h0001; b_key_ld = 1;
    cyc;
    b_key_ld = 0;
    check("b_warm_ready", 32'(b_ready), 32'h0);
    cyc;
    check("b_run_ready", 32'(b_ready), 32'h1);
    b_en = 1; b_din = 8'h0B; qb.push_back(8'h58);
    cyc;
    check("b_v1", 32'(b_v), 32'h1);
    qb.push_back(8'h9A);
    cyc;
    b_en = 0;
    check("b_v2", 32'(b_v), 32'h1);
    cyc;
    check("b_v_off", 32'(b_v), 32'h0);
    check("b_dout_hold", 32'(b_dout), 32'h9A);

    // 4: zero key matches key=1, third byte exercises s=2D00
    b_key = 16'h0000; b_key_ld = 1;
    cyc;
    b_key_ld = 0;
    cyc;
    check("b0_ready", 32'(b_ready), 32'h1);
    b_en = 1; b_din = 8'h0B;
    qb.push_back(8'h58); cyc;
    qb.push_back(8'h9A); cyc;
    qb.push_back(8'h8C); cyc;
    b_en = 0;
    cyc;

    // 5: key_ld and en together, byte dropped, chain restarted
    b_key = 16'h0001; b_key_ld = 1; b_en = 1; b_din = 8'h0B;
    cyc;
    b_key_ld = 0; b_en = 0;
    check("col_v", 32'(b_v), 32'h0);
    check("col_ready", 32'(b_ready), 32'h0);
    cyc;
    check("col_ready_back", 32'(b_ready), 32'h1);
    b_en = 1; qb.push_back(8'h58);
    cyc;
    b_en = 0;
    cyc; cyc;
    check("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
